// File: rtl/vt_scan_pkg.sv
// Shared definitions for the scan sequencer: FSM encodings, default widths, popcount.
package vt_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } scan_state_t;

    localparam int DEF_NUM_CHAINS     = 4;
    localparam int DEF_CHAIN_LEN      = 64;
    localparam int DEF_CAPTURE_CYCLES = 1;
    localparam int DEF_PAT_W          = 16;
    localparam int DEF_FAIL_W         = 16;

    // Widest chain vector popcount accepts; narrower vectors are zero-extended.
    localparam int MAX_CHAINS = 64;

    function automatic logic [7:0] popcount(input logic [MAX_CHAINS-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < MAX_CHAINS; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/vt_scan_cmp.sv
// Masked unload compare: saturating fail counter, sticky per-chain flags, first-fail log.
// Build option: VT_SCAN_FIRST_FAIL_LOG_EN enables the first-fail pattern/bit capture.
module vt_scan_cmp
    import vt_scan_pkg::*;
#(
    parameter int NUM_CHAINS = DEF_NUM_CHAINS,
    parameter int CHAIN_LEN  = DEF_CHAIN_LEN,
    parameter int PAT_W      = DEF_PAT_W,
    parameter int FAIL_W     = DEF_FAIL_W,
    localparam int BIT_W     = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  valid,
    input  logic [NUM_CHAINS-1:0] scan_out,
    input  logic [NUM_CHAINS-1:0] expected,
    input  logic [NUM_CHAINS-1:0] mask,
    input  logic [PAT_W-1:0]      pat_idx,
    input  logic [BIT_W-1:0]      bit_idx,
    output logic [FAIL_W-1:0]     fail_count,
    output logic [NUM_CHAINS-1:0] fail_chain,
    output logic [PAT_W-1:0]      first_fail_pat,
    output logic [BIT_W-1:0]      first_fail_bit
);

    logic [NUM_CHAINS-1:0] miss;
    logic [MAX_CHAINS-1:0] miss_ext;
    logic [FAIL_W+7:0]     sum;

    assign miss = valid ? ((scan_out ^ expected) & mask) : '0;

    always_comb begin
        miss_ext = '0;
        miss_ext[NUM_CHAINS-1:0] = miss;
    end

    // Eight spare bits keep the add from wrapping before the saturation test.
    assign sum = {8'd0, fail_count} + {{FAIL_W{1'b0}}, popcount(miss_ext)};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fail_count <= '0;
            fail_chain <= '0;
        end else if (clear) begin
            fail_count <= '0;
            fail_chain <= '0;
        end else if (valid) begin
            fail_count <= (|sum[FAIL_W+7:FAIL_W]) ? '1 : sum[FAIL_W-1:0];
            fail_chain <= fail_chain | miss;
        end
    end

`ifdef VT_SCAN_FIRST_FAIL_LOG_EN
    logic logged;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            logged         <= 1'b0;
            first_fail_pat <= '0;
            first_fail_bit <= '0;
        end else if (clear) begin
            logged         <= 1'b0;
            first_fail_pat <= '0;
            first_fail_bit <= '0;
        end else if (!logged && (|miss)) begin
            logged         <= 1'b1;
            first_fail_pat <= pat_idx;
            first_fail_bit <= bit_idx;
        end
    end
`else
    logic unused_log;
    assign unused_log     = ^{pat_idx, bit_idx};
    assign first_fail_pat = '0;
    assign first_fail_bit = '0;
`endif

endmodule

// File: rtl/vt_scan_sequencer.sv
// Scan-test sequencer: shift-load / capture / shift-unload with overlapped masked compare.
// Build option: VT_SCAN_FIRST_FAIL_LOG_EN enables first_fail_pat/first_fail_bit logging.
module vt_scan_sequencer
    import vt_scan_pkg::*;
#(
    parameter int NUM_CHAINS     = DEF_NUM_CHAINS,
    parameter int CHAIN_LEN      = DEF_CHAIN_LEN,
    parameter int CAPTURE_CYCLES = DEF_CAPTURE_CYCLES,
    parameter int PAT_W          = DEF_PAT_W,
    parameter int FAIL_W         = DEF_FAIL_W,
    localparam int BIT_W         = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PAT_W-1:0]      num_patterns,
    input  logic                  vec_valid,
    output logic                  vec_ready,
    input  logic [NUM_CHAINS-1:0] vec_si,
    input  logic [NUM_CHAINS-1:0] vec_exp,
    input  logic [NUM_CHAINS-1:0] vec_mask,
    output logic [NUM_CHAINS-1:0] scan_data,
    input  logic [NUM_CHAINS-1:0] scan_out,
    output logic                  scan_en,
    output logic                  dut_clk_en,
    output logic                  busy,
    output logic                  done,
    output logic [FAIL_W-1:0]     fail_count,
    output logic [NUM_CHAINS-1:0] fail_chain,
    output logic [PAT_W-1:0]      first_fail_pat,
    output logic [BIT_W-1:0]      first_fail_bit,
    output scan_state_t           fsm_state
);

    localparam logic [BIT_W-1:0] SHIFT_LAST = BIT_W'(CHAIN_LEN - 1);
    localparam logic [BIT_W-1:0] SHIFT_ONE  = BIT_W'(1);
    localparam logic [3:0]       CAP_LAST   = 4'(CAPTURE_CYCLES - 1);
    localparam logic [PAT_W:0]   PASS_ONE   = (PAT_W+1)'(1);
    localparam logic [PAT_W-1:0] PAT_ONE    = PAT_W'(1);

    scan_state_t           state;
    logic [BIT_W-1:0]      shift_cnt;
    logic [PAT_W:0]        pass_cnt;
    logic [PAT_W-1:0]      np_q;
    logic [3:0]            cap_cnt;
    logic                  beat;
    logic                  start_ok;

    // Compare stage: travels with scan_data so scan_out is checked in the beat's shift cycle.
    logic                  cmp_valid;
    logic [NUM_CHAINS-1:0] cmp_exp;
    logic [NUM_CHAINS-1:0] cmp_mask;
    logic [PAT_W-1:0]      cmp_pat;
    logic [BIT_W-1:0]      cmp_bit;

    // vec_valid/vec_ready: a beat transfers on every cycle both are high (abort cycles excepted);
    // the source may hold vec_valid low to stall, and vec_ready is high only while in SHIFT.
    assign beat      = vec_valid && vec_ready;
    assign start_ok  = (state == ST_IDLE) && start && !abort;
    assign fsm_state = state;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            vec_ready  <= 1'b0;
            scan_en    <= 1'b0;
            dut_clk_en <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            scan_data  <= '0;
            shift_cnt  <= '0;
            pass_cnt   <= '0;
            np_q       <= '0;
            cap_cnt    <= '0;
            cmp_valid  <= 1'b0;
            cmp_exp    <= '0;
            cmp_mask   <= '0;
            cmp_pat    <= '0;
            cmp_bit    <= '0;
        end else begin
            scan_en    <= 1'b0;
            dut_clk_en <= 1'b0;
            done       <= 1'b0;
            cmp_valid  <= 1'b0;
            if (abort) begin
                state     <= ST_IDLE;
                vec_ready <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state     <= ST_SHIFT;
                            vec_ready <= 1'b1;
                            busy      <= 1'b1;
                            np_q      <= num_patterns;
                            pass_cnt  <= '0;
                            shift_cnt <= '0;
                        end
                    end
                    ST_SHIFT: begin
                        if (beat) begin
                            dut_clk_en <= 1'b1;
                            scan_en    <= 1'b1;
                            scan_data  <= vec_si;
                            cmp_valid  <= 1'b1;
                            cmp_exp    <= vec_exp;
                            // Pass 0 unloads whatever the chains held before start.
                            cmp_mask   <= (pass_cnt != '0) ? vec_mask : '0;
                            cmp_pat    <= pass_cnt[PAT_W-1:0] - PAT_ONE;
                            cmp_bit    <= shift_cnt;
                            if (shift_cnt == SHIFT_LAST) begin
                                shift_cnt <= '0;
                                vec_ready <= 1'b0;
                                if (pass_cnt < {1'b0, np_q}) begin
                                    state   <= ST_CAPTURE;
                                    cap_cnt <= '0;
                                end else begin
                                    state <= ST_DONE;
                                end
                            end else begin
                                shift_cnt <= shift_cnt + SHIFT_ONE;
                            end
                        end
                    end
                    ST_CAPTURE: begin
                        dut_clk_en <= 1'b1;
                        if (cap_cnt == CAP_LAST) begin
                            state     <= ST_SHIFT;
                            vec_ready <= 1'b1;
                            pass_cnt  <= pass_cnt + PASS_ONE;
                        end else begin
                            cap_cnt <= cap_cnt + 4'd1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    vt_scan_cmp #(
        .NUM_CHAINS (NUM_CHAINS),
        .CHAIN_LEN  (CHAIN_LEN),
        .PAT_W      (PAT_W),
        .FAIL_W     (FAIL_W)
    ) u_cmp (
        .clock          (clock),
        .reset          (reset),
        .clear          (start_ok),
        .valid          (cmp_valid),
        .scan_out       (scan_out),
        .expected       (cmp_exp),
        .mask           (cmp_mask),
        .pat_idx        (cmp_pat),
        .bit_idx        (cmp_bit),
        .fail_count     (fail_count),
        .fail_chain     (fail_chain),
        .first_fail_pat (first_fail_pat),
        .first_fail_bit (first_fail_bit)
    );

endmodule

// File: tb/tb_vt_scan_sequencer.sv
// Bench for vt_scan_sequencer: behavioural scan-chain DUT model plus scan_data scoreboard.
// Expected first-fail values follow VT_SCAN_FIRST_FAIL_LOG_EN.
module tb_vt_scan_sequencer;
    import vt_scan_pkg::*;

    localparam int NC = 4;
    localparam int L  = 8;
    localparam int C  = 3;
    localparam int PW = 8;
    localparam int FW = 4;
    localparam int BW = $clog2(L);
`ifdef VT_SCAN_FIRST_FAIL_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [PW-1:0] num_patterns = '0;
    logic          vec_valid = 1'b0;
    logic          vec_ready;
    logic [NC-1:0] vec_si = '0;
    logic [NC-1:0] vec_exp = '0;
    logic [NC-1:0] vec_mask = '0;
    logic [NC-1:0] scan_data;
    logic [NC-1:0] scan_out;
    logic          scan_en;
    logic          dut_clk_en;
    logic          busy;
    logic          done;
    logic [FW-1:0] fail_count;
    logic [NC-1:0] fail_chain;
    logic [PW-1:0] first_fail_pat;
    logic [BW-1:0] first_fail_bit;
    scan_state_t   fsm_state;

    int checks = 0;
    int passed = 0;
    logic [NC-1:0] exp_q[$];

    // DUT model controls, written only by the test tasks.
    bit            flip_en  = 1'b0;
    int            flip_g   = 0;
    logic [NC-1:0] flip_bits = '0;
    bit            all_fail = 1'b0;

    vt_scan_sequencer #(
        .NUM_CHAINS(NC), .CHAIN_LEN(L), .CAPTURE_CYCLES(C), .PAT_W(PW), .FAIL_W(FW)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .num_patterns(num_patterns), .vec_valid(vec_valid), .vec_ready(vec_ready),
        .vec_si(vec_si), .vec_exp(vec_exp), .vec_mask(vec_mask), .scan_data(scan_data),
        .scan_out(scan_out), .scan_en(scan_en), .dut_clk_en(dut_clk_en), .busy(busy),
        .done(done), .fail_count(fail_count), .fail_chain(fail_chain),
        .first_fail_pat(first_fail_pat), .first_fail_bit(first_fail_bit),
        .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    // ---------------- DUT scan-chain model ----------------
    // ch[0] is the scan-in end; each capture pulse inverts every cell.
    logic [NC-1:0] ch [L];
    int g;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < L; k++) ch[k] <= '0;
            g <= 0;
        end else begin
            if (start && !busy) g <= 0;
            else if (dut_clk_en && scan_en) g <= g + 1;
            if (dut_clk_en) begin
                if (scan_en) begin
                    ch[0] <= scan_data;
                    for (int k = 1; k < L; k++) ch[k] <= ch[k-1];
                end else begin
                    for (int k = 0; k < L; k++) ch[k] <= ~ch[k];
                end
            end
        end
    end

    always_comb begin
        scan_out = ch[L-1];
        if (flip_en && g == flip_g) scan_out = scan_out ^ flip_bits;
        if (all_fail && g >= L) scan_out = ~scan_out;
    end

    // ---------------- driver ----------------
    // Runs one start..done sequence; unload expectations are the inverse of the previous pass.
    task automatic run_scan(input int np, input int stall_beat, input int stall_len,
                            input logic [NC-1:0] mask, input bit poke_start,
                            output int cycles, output int caps, output int shifts);
        int total;
        int b;
        int stall_left;
        bit consume;
        bit need_new;
        bit got_done;
        logic [NC-1:0] si_hist[$];
        logic [NC-1:0] req;
        total = (np + 1) * L;
        b = 0; stall_left = stall_len; consume = 0; need_new = 1; got_done = 0;
        cycles = 0; caps = 0; shifts = 0;
        exp_q.delete();
        @(negedge clock);
        num_patterns = PW'(np);
        start = 1'b1;
        vec_valid = 1'b0;
        @(negedge clock);
        start = 1'b0;
        cycles = 1;
        while (!got_done && cycles < 600) begin
            if (consume) begin
                exp_q.push_back(vec_si);
                si_hist.push_back(vec_si);
                b++;
                need_new = 1;
            end
            if (dut_clk_en && scan_en) begin
                shifts++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL scan_data_unexpected: got %h with no beat pending", scan_data);
                end else begin
                    req = exp_q.pop_front();
                    if (scan_data !== req)
                        $display("FAIL scan_data: got %h expected %h (shift %0d)", scan_data, req, shifts);
                    else passed++;
                end
            end
            if (dut_clk_en && !scan_en) caps++;
            if (done) begin
                got_done = 1;
            end else begin
                start = poke_start && (cycles == 10);
                if (b < total && b == stall_beat && stall_left > 0) begin
                    vec_valid = 1'b0;
                    stall_left--;
                end else if (b < total) begin
                    if (need_new) begin
                        vec_si   = NC'($urandom_range(0, (1 << NC) - 1));
                        vec_exp  = (b >= L) ? ~si_hist[b-L] : NC'($urandom_range(0, (1 << NC) - 1));
                        vec_mask = mask;
                        need_new = 0;
                    end
                    vec_valid = 1'b1;
                end else begin
                    vec_valid = 1'b0;
                end
                consume = vec_valid && vec_ready;
                @(negedge clock);
                cycles++;
            end
        end
        vec_valid = 1'b0;
        start = 1'b0;
        if (!got_done) begin
            checks++;
            $display("FAIL done_timeout: no done after %0d cycles", cycles);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({busy, done, vec_ready, scan_en, dut_clk_en} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, vec_ready, scan_en, dut_clk_en});
        else passed++;
        checks++;
        if ({scan_data, fail_count, fail_chain} !== '0)
            $display("FAIL reset_data: got %h expected 0", {scan_data, fail_count, fail_chain});
        else passed++;
        checks++;
        if ({first_fail_pat, first_fail_bit} !== '0 || fsm_state !== ST_IDLE)
            $display("FAIL reset_log_state: got %h/%0d expected 0/IDLE", {first_fail_pat, first_fail_bit}, fsm_state);
        else passed++;
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic check_result(input string name, input int cyc, input int cyc_req,
                                input int caps, input int shifts, input int np,
                                input logic [FW-1:0] fc_req, input logic [NC-1:0] chain_req);
        checks++;
        if (cyc !== cyc_req) $display("FAIL %s_latency: got %0d expected %0d", name, cyc, cyc_req);
        else passed++;
        checks++;
        if (shifts !== (np + 1) * L || caps !== np * C)
            $display("FAIL %s_pulses: got shifts %0d caps %0d expected %0d %0d", name, shifts, caps, (np + 1) * L, np * C);
        else passed++;
        checks++;
        if (fail_count !== fc_req || fail_chain !== chain_req)
            $display("FAIL %s_fails: got %h/%b expected %h/%b", name, fail_count, fail_chain, fc_req, chain_req);
        else passed++;
        checks++;
        if (busy !== 1'b0 || exp_q.size() != 0)
            $display("FAIL %s_idle: got busy %b pending %0d expected 0 0", name, busy, exp_q.size());
        else passed++;
    endtask

    task automatic test_basic;
        int cyc, caps, shifts;
        run_scan(2, -1, 0, '1, 1'b0, cyc, caps, shifts);
        check_result("basic", cyc, 3 * L + 2 * C + 2, caps, shifts, 2, '0, '0);
    endtask

    task automatic test_single_fail;
        int cyc, caps, shifts;
        flip_en = 1'b1; flip_g = L + 3; flip_bits = 4'b0100;
        run_scan(2, -1, 0, 4'hF, 1'b0, cyc, caps, shifts);
        flip_en = 1'b0;
        check_result("single_fail", cyc, 3 * L + 2 * C + 2, caps, shifts, 2, 4'd1, 4'b0100);
        checks++;
        if (first_fail_pat !== PW'(0) || first_fail_bit !== (LOG_EN ? BW'(3) : BW'(0)))
            $display("FAIL first_fail: got %0d/%0d expected 0/%0d", first_fail_pat, first_fail_bit, LOG_EN ? 3 : 0);
        else passed++;
    endtask

    task automatic test_masked_fail;
        int cyc, caps, shifts;
        flip_en = 1'b1; flip_g = L + 3; flip_bits = 4'b0100;
        run_scan(2, -1, 0, 4'h0, 1'b0, cyc, caps, shifts);
        check_result("mask_off", cyc, 3 * L + 2 * C + 2, caps, shifts, 2, '0, '0);
        flip_g = 3;
        run_scan(2, -1, 0, 4'hF, 1'b0, cyc, caps, shifts);
        flip_en = 1'b0;
        check_result("pass0_fail", cyc, 3 * L + 2 * C + 2, caps, shifts, 2, '0, '0);
    endtask

    task automatic test_stall;
        int cyc, caps, shifts;
        run_scan(2, L + 4, 5, '1, 1'b0, cyc, caps, shifts);
        check_result("stall", cyc, 3 * L + 2 * C + 2 + 5, caps, shifts, 2, '0, '0);
    endtask

    task automatic test_start_while_busy;
        int cyc, caps, shifts;
        run_scan(1, -1, 0, '1, 1'b1, cyc, caps, shifts);
        check_result("start_busy", cyc, 2 * L + C + 2, caps, shifts, 1, '0, '0);
    endtask

    task automatic test_saturation;
        int cyc, caps, shifts;
        all_fail = 1'b1;
        run_scan(2, -1, 0, 4'hF, 1'b0, cyc, caps, shifts);
        all_fail = 1'b0;
        check_result("saturate", cyc, 3 * L + 2 * C + 2, caps, shifts, 2, 4'hF, 4'hF);
        checks++;
        if (first_fail_pat !== PW'(0) || first_fail_bit !== BW'(0))
            $display("FAIL sat_first_fail: got %0d/%0d expected 0/0", first_fail_pat, first_fail_bit);
        else passed++;
    endtask

    task automatic test_abort;
        int caps, cyc, shifts, n;
        bit seen_done;
        // All-zero load: captured chains read back all-ones, model inverts them -> 4 misses per beat.
        all_fail = 1'b1;
        @(negedge clock);
        num_patterns = PW'(2); start = 1'b1;
        @(negedge clock);
        start = 1'b0; vec_si = '0; vec_exp = '1; vec_mask = '1; vec_valid = 1'b1;
        caps = 0; n = 0;
        while (caps < C + 1 && n < 200) begin
            @(negedge clock);
            n++;
            if (dut_clk_en && !scan_en) caps++;
        end
        checks++;
        if (fsm_state !== ST_CAPTURE) $display("FAIL abort_pre_state: got %0d expected %0d", fsm_state, ST_CAPTURE);
        else passed++;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        checks++;
        if ({busy, scan_en, dut_clk_en, vec_ready, done} !== 5'b0 || fsm_state !== ST_IDLE)
            $display("FAIL abort_idle: got %b state %0d expected 00000 IDLE", {busy, scan_en, dut_clk_en, vec_ready, done}, fsm_state);
        else passed++;
        checks++;
        if (fail_count !== 4'hF || fail_chain !== 4'hF)
            $display("FAIL abort_hold: got %h/%h expected f/f", fail_count, fail_chain);
        else passed++;
        seen_done = 0;
        start = 1'b1; abort = 1'b1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0; vec_valid = 1'b0; all_fail = 1'b0;
        repeat (40) begin
            if (done) seen_done = 1;
            @(negedge clock);
        end
        checks++;
        if (seen_done || busy !== 1'b0 || fail_count !== 4'hF)
            $display("FAIL abort_start_same: got done %b busy %b fc %h expected 0 0 f", seen_done, busy, fail_count);
        else passed++;
        run_scan(0, -1, 0, '1, 1'b0, cyc, caps, shifts);
        check_result("restart", cyc, L + 2, caps, shifts, 0, '0, '0);
    endtask

    task automatic test_reset_midrun;
        all_fail = 1'b1;
        @(negedge clock);
        num_patterns = PW'(2); start = 1'b1;
        @(negedge clock);
        start = 1'b0; vec_si = '0; vec_exp = '1; vec_mask = '1; vec_valid = 1'b1;
        repeat (22) @(negedge clock);
        checks++;
        if (fail_count !== 4'hF) $display("FAIL midrun_pre: got %h expected f", fail_count);
        else passed++;
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, scan_en, dut_clk_en, vec_ready, fail_count, fail_chain} !== '0 || fsm_state !== ST_IDLE)
            $display("FAIL midrun_reset: got %h state %0d expected 0 IDLE",
                     {busy, scan_en, dut_clk_en, vec_ready, fail_count, fail_chain}, fsm_state);
        else passed++;
        vec_valid = 1'b0; all_fail = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_single_fail;
        test_masked_fail;
        test_stall;
        test_start_while_busy;
        test_saturation;
        test_abort;
        test_reset_midrun;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
